// File: rtl/ysyx_23060201_mem_arbiter.sv
// ysyx_23060201_mem_arbiter
// Two-requester arbiter and transaction sequencer for the core's single
// memory port. Grants IFU (fetch, read-only) or LSU (load/store) one at a
// time, registers the winning request, drives it to memory and routes the
// response back to its owner as a one-cycle pulse.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ifu_req_*         fetch request (valid/ready) and address
//   ifu_rsp_*         fetch response pulse and data
//   lsu_req_*         load/store request (valid/ready), wen, addr, wdata, wmask
//   lsu_rsp_*         load data / store ack pulse (rdata is 0 for stores)
//   mem_req_*         memory request (valid/ready), wen, addr, wdata, wmask
//   mem_rsp_*         memory response (read data or write ack)
//   busy              transaction in progress
//
// Configuration macro:
//   YSYX_23060201_ARB_RR_EN  defined   -> round-robin tie-break
//                            undefined -> fixed priority, LSU over IFU
module ysyx_23060201_mem_arbiter #(
   parameter int unsigned MEM_ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [MEM_ADDR_WIDTH-1:0] ifu_addr,
   output logic                      ifu_rsp_valid,
   output logic [DATA_WIDTH-1:0]     ifu_rdata,
   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic                      lsu_wen,
   input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [7:0]                lsu_wmask,
   output logic                      lsu_rsp_valid,
   output logic [DATA_WIDTH-1:0]     lsu_rdata,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_wen,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [7:0]                mem_wmask,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy
);

   localparam int unsigned MASK_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   state_e                    state_q, state_d;
   logic                      owner_q, owner_d;
   logic                      wen_q, wen_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [MASK_W-1:0]         wmask_q, wmask_d;
   logic                      ifu_rsp_valid_q, ifu_rsp_valid_d;
   logic                      lsu_rsp_valid_q, lsu_rsp_valid_d;
   logic [DATA_WIDTH-1:0]     ifu_rdata_q, ifu_rdata_d;
   logic [DATA_WIDTH-1:0]     lsu_rdata_q, lsu_rdata_d;
`ifdef YSYX_23060201_ARB_RR_EN
   logic                      last_grant_q, last_grant_d;
`endif

   logic grant_ifu;
   logic grant_lsu;
   logic rsp_take;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         owner_q         <= OWN_IFU;
         wen_q           <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         wmask_q         <= '0;
         ifu_rsp_valid_q <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;
         ifu_rdata_q     <= '0;
         lsu_rdata_q     <= '0;
`ifdef YSYX_23060201_ARB_RR_EN
         last_grant_q    <= OWN_IFU;
`endif
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         wen_q           <= wen_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         wmask_q         <= wmask_d;
         ifu_rsp_valid_q <= ifu_rsp_valid_d;
         lsu_rsp_valid_q <= lsu_rsp_valid_d;
         ifu_rdata_q     <= ifu_rdata_d;
         lsu_rdata_q     <= lsu_rdata_d;
`ifdef YSYX_23060201_ARB_RR_EN
         last_grant_q    <= last_grant_d;
`endif
      end
   end

   // Arbitration: only in IDLE, never grants an invalid request
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state_q == S_IDLE) begin
`ifdef YSYX_23060201_ARB_RR_EN
         if (ifu_req_valid && lsu_req_valid) begin
            // Tie goes to whoever did not win last time
            grant_lsu = (last_grant_q == OWN_IFU);
            grant_ifu = ~grant_lsu;
         end else begin
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_req_valid;
         end
`else
         grant_lsu = lsu_req_valid;
         grant_ifu = ifu_req_valid & ~lsu_req_valid;
`endif
      end
   end

   assign rsp_take = (state_q == S_WAIT) && mem_rsp_valid;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_ifu || grant_lsu) state_d = S_REQ;
         S_REQ:   if (mem_req_ready)          state_d = S_WAIT;
         S_WAIT:  if (mem_rsp_valid)          state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Grant handshake, request latch and response capture
   always_comb begin
      ifu_req_ready   = grant_ifu;
      lsu_req_ready   = grant_lsu;
      owner_d         = owner_q;
      wen_d           = wen_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      wmask_d         = wmask_q;
      ifu_rsp_valid_d = 1'b0;
      lsu_rsp_valid_d = 1'b0;
      ifu_rdata_d     = ifu_rdata_q;
      lsu_rdata_d     = lsu_rdata_q;
`ifdef YSYX_23060201_ARB_RR_EN
      last_grant_d    = last_grant_q;
`endif

      if (grant_lsu) begin
         owner_d = OWN_LSU;
         wen_d   = lsu_wen;
         addr_d  = lsu_addr;
         wdata_d = lsu_wdata;
         // Loads carry no byte mask on the memory side
         wmask_d = lsu_wen ? lsu_wmask : MASK_W'(0);
`ifdef YSYX_23060201_ARB_RR_EN
         last_grant_d = OWN_LSU;
`endif
      end else if (grant_ifu) begin
         owner_d = OWN_IFU;
         wen_d   = 1'b0;
         addr_d  = ifu_addr;
         wdata_d = '0;
         wmask_d = '0;
`ifdef YSYX_23060201_ARB_RR_EN
         last_grant_d = OWN_IFU;
`endif
      end

      if (rsp_take) begin
         if (owner_q == OWN_LSU) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = wen_q ? DATA_WIDTH'(0) : mem_rdata;
         end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = mem_rdata;
         end
      end
   end

   // Memory side is driven purely from registered state
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_wen       = wen_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign busy          = (state_q != S_IDLE);

   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign ifu_rdata     = ifu_rdata_q;
   assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Testbench for ysyx_23060201_mem_arbiter: directed stimulus with a
// scoreboard of expected memory requests and owner responses, checked by an
// independent monitor on the falling edge.
module tb_ysyx_23060201_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [7:0]    lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [7:0]    mem_wmask;
   logic          busy;

   ysyx_23060201_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } mreq_t;

   typedef struct packed {
      logic        lsu;
      logic [31:0] data;
   } rsp_t;

   mreq_t exp_mem_q[$];
   rsp_t  exp_rsp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;
   mreq_t mon_m;
   rsp_t  mon_r;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got 0x%0h with nothing expected", name, act);
   endtask

   // Monitor: memory-side accepts and owner response pulses
   always @(negedge clk) begin
      if (rst_n && mem_req_valid && mem_req_ready) begin
         if (exp_mem_q.size() == 0) begin
            fail_now("mem_req_unexpected", 64'(mem_addr));
         end else begin
            mon_m = exp_mem_q.pop_front();
            chk("mem_wen",   64'(mem_wen),   64'(mon_m.wen));
            chk("mem_addr",  64'(mem_addr),  64'(mon_m.addr));
            chk("mem_wmask", 64'(mem_wmask), 64'(mon_m.wmask));
            if (mon_m.wen) chk("mem_wdata", 64'(mem_wdata), 64'(mon_m.wdata));
         end
      end
      if (ifu_rsp_valid || lsu_rsp_valid) begin
         if (ifu_rsp_valid && lsu_rsp_valid) begin
            fail_now("rsp_both_owners", 64'({ifu_rsp_valid, lsu_rsp_valid}));
         end else if (exp_rsp_q.size() == 0) begin
            fail_now("rsp_unexpected", 64'({ifu_rsp_valid, lsu_rsp_valid}));
         end else begin
            mon_r = exp_rsp_q.pop_front();
            chk("rsp_owner", 64'(lsu_rsp_valid), 64'(mon_r.lsu));
            chk("rsp_data", 64'(lsu_rsp_valid ? lsu_rdata : ifu_rdata), 64'(mon_r.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Grant cycle: request already driven, DUT in IDLE
   task automatic grant(input bit lsu, input mreq_t m, output int gc);
      @(negedge clk);
      chk("ifu_req_ready", 64'(ifu_req_ready), 64'(!lsu));
      chk("lsu_req_ready", 64'(lsu_req_ready), 64'(lsu));
      chk("busy_at_grant", 64'(busy), 64'(0));
      exp_mem_q.push_back(m);
      gc = cyc;
      step();
   endtask

   // REQ stall, accept, WAIT cycles and response; returns in the pulse cycle
   task automatic serve(input int stall, input bit spurious, input int wt,
                        input mreq_t m, input rsp_t r, input logic [31:0] rd);
      for (int i = 0; i < stall; i++) begin
         mem_req_ready = 1'b0;
         mem_rsp_valid = spurious;
         mem_rdata     = 32'hBAD0_0000 + 32'(i);
         @(negedge clk);
         chk("stall_req_valid", 64'({mem_req_valid, busy}), 64'(2'b11));
         chk("stall_addr",  64'(mem_addr),  64'(m.addr));
         chk("stall_wmask", 64'({mem_wen, mem_wmask}), 64'({m.wen, m.wmask}));
         if (m.wen) chk("stall_wdata", 64'(mem_wdata), 64'(m.wdata));
         step();
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < wt; i++) begin
         @(negedge clk);
         chk("wait_state", 64'({busy, mem_req_valid, ifu_req_ready, lsu_req_ready}), 64'(4'b1000));
         step();
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = rd;
      exp_rsp_q.push_back(r);
      step();
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      mreq_t m;
      int    g, gprev;
      rst_n = 1'b0;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      repeat (3) step();
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("reset_ctrl", 64'({busy, mem_req_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid,
                             ifu_req_ready, lsu_req_ready}), 64'(0));
      chk("reset_addr_mask", 64'({mem_addr, mem_wmask}), 64'(0));
      chk("reset_rdata", {ifu_rdata, lsu_rdata}, 64'(0));
      step();

      // Simultaneous requests held across two arbitrations
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
      lsu_wdata = 32'h0; lsu_wmask = 8'hFF;
      m = '{wen: 1'b0, addr: 32'h8000_2000, wdata: 32'h0, wmask: 8'h00};
      grant(1'b1, m, g);
      lsu_addr = 32'h8000_2004;
      serve(0, 1'b0, 1, m, '{lsu: 1'b1, data: 32'h1111_2222}, 32'h1111_2222);
`ifdef YSYX_23060201_ARB_RR_EN
      m = '{wen: 1'b0, addr: 32'h8000_0100, wdata: 32'h0, wmask: 8'h00};
      grant(1'b0, m, g);
      serve(0, 1'b0, 0, m, '{lsu: 1'b0, data: 32'h3333_4444}, 32'h3333_4444);
`else
      m = '{wen: 1'b0, addr: 32'h8000_2004, wdata: 32'h0, wmask: 8'h00};
      grant(1'b1, m, g);
      serve(0, 1'b0, 0, m, '{lsu: 1'b1, data: 32'h3333_4444}, 32'h3333_4444);
`endif
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      step();

      // Single fetch, zero memory wait
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      m = '{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00};
      grant(1'b0, m, g);
      ifu_req_valid = 1'b0;
      serve(0, 1'b0, 0, m, '{lsu: 1'b0, data: 32'h0000_0413}, 32'h0000_0413);
      @(negedge clk);
      chk("fetch_rsp_at_t3", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(2'b10));
      step();
      @(negedge clk);
      chk("fetch_rdata_hold", 64'({ifu_rsp_valid, ifu_rdata}), 64'({1'b0, 32'h0000_0413}));
      step();

      // Store with three REQ stall cycles and spurious responses during REQ
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
      m = '{wen: 1'b1, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF, wmask: 8'h0F};
      grant(1'b1, m, g);
      lsu_req_valid = 1'b0;
      serve(3, 1'b1, 1, m, '{lsu: 1'b1, data: 32'h0}, 32'hCAFE_F00D);
      step();

      // Spurious response while IDLE
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0055;
      step();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("idle_spurious", 64'({busy, ifu_rdata, lsu_rdata}), 64'({1'b0, 32'h0000_0413, 32'h0}));
      step();

      // Reset while in WAIT, then a late response
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
      m = '{wen: 1'b0, addr: 32'h8000_0040, wdata: 32'h0, wmask: 8'h00};
      grant(1'b0, m, g);
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("wait_busy", 64'(busy), 64'(1));
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0077;
      step();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_ctrl", 64'({busy, mem_req_valid, mem_wen, ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
      chk("post_reset_data", 64'({mem_addr, mem_wmask}), 64'(0));
      chk("post_reset_rdata", {ifu_rdata, lsu_rdata}, 64'(0));
      step();

      // Back-to-back fetches: grant every third cycle
      ifu_req_valid = 1'b1;
      gprev = 0;
      for (int k = 0; k < 3; k++) begin
         ifu_addr = 32'h8000_0000 + 32'(4 * k);
         m = '{wen: 1'b0, addr: 32'h8000_0000 + 32'(4 * k), wdata: 32'h0, wmask: 8'h00};
         grant(1'b0, m, g);
         if (k > 0) chk("b2b_grant_spacing", 64'(g - gprev), 64'(3));
         gprev = g;
         serve(0, 1'b0, 0, m, '{lsu: 1'b0, data: 32'h0000_1000 + 32'(k)}, 32'h0000_1000 + 32'(k));
      end
      ifu_req_valid = 1'b0;
      repeat (3) step();

      chk("scoreboard_drained", 64'(exp_mem_q.size() + exp_rsp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
